// File: rtl/conv_pkg.sv
// Shared types for the convolution datapath: pixel and 2x2 window layouts
// plus the window-generator frame states.
package conv_pkg;

    typedef logic [7:0]   pixel_t;
    typedef pixel_t [3:0] window_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } win_state_e;

    localparam int WIN_TL = 0;
    localparam int WIN_TR = 1;
    localparam int WIN_BL = 2;
    localparam int WIN_BR = 3;

    // Places four pixels into the slot order the neuron's pixels input expects.
    function automatic window_t pack_window(input pixel_t tl, input pixel_t tr,
                                            input pixel_t bl, input pixel_t br);
        window_t w;
        w[WIN_TL] = tl;
        w[WIN_TR] = tr;
        w[WIN_BL] = bl;
        w[WIN_BR] = br;
        return w;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle between a raster source, the window
// generator and the convolution neuron.
interface conv_window_gen_if;
    import conv_pkg::*;

    logic    pix_valid;
    logic    pix_sof;
    pixel_t  pix_in;
    logic    win_valid;
    window_t win_pixels;
    logic    win_last;
    logic    frame_err;

    modport master (
        output pix_valid, pix_sof, pix_in,
        input  win_valid, win_pixels, win_last, frame_err
    );

    modport slave (
        input  pix_valid, pix_sof, pix_in,
        output win_valid, win_pixels, win_last, frame_err
    );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One-row pixel store: combinational read of the addressed entry, write on
// the clock edge, so a same-cycle access returns the old value.
module line_buffer
    import conv_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  pixel_t        i_wdata,
    output pixel_t        o_rdata
);

    pixel_t r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // NOTE: storage has no reset; every entry is rewritten during row 0
    // before STREAM ever reads it, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 2x2 stride-1 windows: frame FSM, col/row counters,
// column-1 holding registers and registered window outputs.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input logic               clk,
    input logic               rst_n,
    conv_window_gen_if.slave  bus
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    win_state_e       r_state;
    win_state_e       w_next_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    pixel_t           r_prev_top;
    pixel_t           r_prev_bot;
    logic             r_win_valid;
    logic             r_win_last;
    logic             r_frame_err;
    window_t          r_win_pixels;

    logic             w_sof;
    logic             w_accept;
    logic             w_fire;
    logic             w_last;
    logic             w_err;
    logic [COL_W-1:0] w_lb_addr;
    pixel_t           w_lb_rdata;

    assign w_sof    = bus.pix_valid & bus.pix_sof;
    assign w_accept = bus.pix_valid & (w_sof | (r_state != IDLE));
    // A sof pixel is always column 0, whatever the counter held before.
    assign w_lb_addr = w_sof ? '0 : r_col;

    line_buffer #(.DEPTH(IMG_W)) u_line_buf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_lb_addr),
        .i_wdata (bus.pix_in),
        .o_rdata (w_lb_rdata)
    );

    // NOTE: every output of this block is defaulted first so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_fire       = 1'b0;
        w_last       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sof) w_next_state = FILL;
            end
            FILL: begin
                if (w_sof) begin
                    w_err = 1'b1;
                end else if (bus.pix_valid && r_col == COL_MAX) begin
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                if (w_sof) begin
                    w_err        = 1'b1;
                    w_next_state = FILL;
                end else if (bus.pix_valid) begin
                    w_fire = (r_col != '0);
                    if (r_col == COL_MAX && r_row == ROW_MAX) begin
                        w_last       = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_prev_top <= '0;
            r_prev_bot <= '0;
        end else if (w_accept) begin
            r_prev_top <= w_lb_rdata;
            r_prev_bot <= bus.pix_in;
            if (w_sof) begin
                r_col <= COL_W'(1);
                r_row <= '0;
            end else if (r_col == COL_MAX) begin
                r_col <= '0;
                r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid  <= 1'b0;
            r_win_last   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_win_pixels <= '0;
        end else begin
            r_win_valid <= w_fire;
            r_win_last  <= w_last;
            r_frame_err <= w_err;
            if (w_fire) begin
                r_win_pixels <= pack_window(r_prev_top, w_lb_rdata,
                                            r_prev_bot, bus.pix_in);
            end
        end
    end

    assign bus.win_valid  = r_win_valid;
    assign bus.win_last   = r_win_last;
    assign bus.frame_err  = r_frame_err;
    assign bus.win_pixels = r_win_pixels;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: a 4x4 instance under directed and
// randomized frames, plus a 2x2 instance for the minimum-size frame.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    typedef struct {
        window_t px;
        logic    last;
        int      t;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   err4    = 0;
    int   stray   = 0;

    obs_t q4[$];
    obs_t q2[$];
    obs_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    conv_window_gen_if u_if ();
    conv_window_gen_if u_if2 ();

    conv_window_gen #(.IMG_W(W), .IMG_H(H)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    conv_window_gen #(.IMG_W(2), .IMG_H(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if2)
    );

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (u_if.win_valid) q4.push_back('{px: u_if.win_pixels, last: u_if.win_last, t: cyc});
        if (u_if2.win_valid) q2.push_back('{px: u_if2.win_pixels, last: u_if2.win_last, t: cyc});
        if (u_if.frame_err) err4++;
        if (u_if.win_last && !u_if.win_valid) stray++;
        if (u_if2.win_last && !u_if2.win_valid) stray++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic v, input logic s, input pixel_t p);
        @(posedge clk);
        #1;
        u_if.pix_valid = v;
        u_if.pix_sof   = s;
        u_if.pix_in    = p;
    endtask

    // Drives n pixels of img (sof on the first); tacc gets the cycle in which
    // each pixel's window, if any, must appear.
    task automatic play(input pixel_t img[N], input int n, input int gap_mode,
                        output int tacc[N]);
        for (int i = 0; i < N; i++) tacc[i] = 0;
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int k = 0; k < g; k++) send(1'b0, 1'b0, pixel_t'($urandom));
            send(1'b1, (i == 0), img[i]);
            tacc[i] = cyc + 1;
        end
        send(1'b0, 1'b0, 8'h00);
    endtask

    // Reference: every 2x2 neighbourhood whose bottom-right pixel was sent,
    // in raster order of that pixel.
    task automatic add_expected(input pixel_t img[N], input int tacc[N], input int n);
        for (int r = 1; r < H; r++) begin
            for (int c = 1; c < W; c++) begin
                int br;
                obs_t o;
                br = r * W + c;
                if (br < n) begin
                    o.px[WIN_TL] = img[br - W - 1];
                    o.px[WIN_TR] = img[br - W];
                    o.px[WIN_BL] = img[br - 1];
                    o.px[WIN_BR] = img[br];
                    o.last       = (r == H - 1) && (c == W - 1);
                    o.t          = tacc[br];
                    exp_q.push_back(o);
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        repeat (3) send(1'b0, 1'b0, 8'h00);
        check($sformatf("%s/count", tag), 32'(q4.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < q4.size(); i++) begin
            check($sformatf("%s/w%0d/px", tag, i), q4[i].px, exp_q[i].px);
            check($sformatf("%s/w%0d/last", tag, i), 32'(q4[i].last), 32'(exp_q[i].last));
            check($sformatf("%s/w%0d/time", tag, i), 32'(q4[i].t), 32'(exp_q[i].t));
        end
        q4.delete();
        exp_q.delete();
    endtask

    initial begin
        pixel_t img[N];
        pixel_t img2[N];
        pixel_t rimg[N];
        int     ta[N];
        int     tb2[N];
        int     err0;
        int     t_last;

        u_if.pix_valid  = 1'b0;
        u_if.pix_sof    = 1'b0;
        u_if.pix_in     = 8'h00;
        u_if2.pix_valid = 1'b0;
        u_if2.pix_sof   = 1'b0;
        u_if2.pix_in    = 8'h00;
        for (int i = 0; i < N; i++) begin
            img[i]  = pixel_t'(i + 1);
            img2[i] = pixel_t'(101 + i);
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/win_valid", 32'(u_if.win_valid), 32'd0);
        check("rst/win_last", 32'(u_if.win_last), 32'd0);
        check("rst/frame_err", 32'(u_if.frame_err), 32'd0);
        check("rst/win_pixels", u_if.win_pixels, 32'd0);
        check("rst/win_valid2", 32'(u_if2.win_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Continuous 4x4 frame 1..16
        play(img, N, 0, ta);
        add_expected(img, ta, N);
        repeat (2) send(1'b0, 1'b0, 8'h00);
        check("s1/first", (q4.size() > 0) ? q4[0].px : 32'd0, {8'd6, 8'd5, 8'd2, 8'd1});
        check("s1/second", (q4.size() > 1) ? q4[1].px : 32'd0, {8'd7, 8'd6, 8'd3, 8'd2});
        check("s1/lastpx", (q4.size() > 8) ? q4[8].px : 32'd0, {8'd16, 8'd15, 8'd12, 8'd11});
        check("s1/lastflag", (q4.size() > 8) ? 32'(q4[8].last) : 32'd0, 32'd1);
        compare("s1");
        check("s1/frame_err", 32'(err4), 32'd0);

        // Same frame, pix_valid low every other cycle
        play(img, N, 1, ta);
        add_expected(img, ta, N);
        compare("s2");

        // Pixels before any sof are dropped
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, pixel_t'($urandom));
        play(img, N, 0, ta);
        add_expected(img, ta, N);
        compare("s3");

        // sof injected as the 10th pixel, then a full frame 101..116
        err0 = err4;
        play(img, 9, 0, ta);
        play(img2, N, 0, tb2);
        add_expected(img, ta, 9);
        add_expected(img2, tb2, N);
        repeat (2) send(1'b0, 1'b0, 8'h00);
        check("s4/frame_err_pulses", 32'(err4 - err0), 32'd1);
        check("s4/first_new", (q4.size() > 3) ? q4[3].px : 32'd0,
              {8'd106, 8'd105, 8'd102, 8'd101});
        compare("s4");

        // Randomized frames with random gaps
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) rimg[i] = pixel_t'($urandom);
            play(rimg, N, 2, ta);
            add_expected(rimg, ta, N);
            compare($sformatf("s5/f%0d", f));
        end

        // Asynchronous reset while a window is on the outputs
        play(img, 6, 0, ta);
        @(negedge clk);
        check("s6/pre_valid", 32'(u_if.win_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("s6/rst_valid", 32'(u_if.win_valid), 32'd0);
        check("s6/rst_last", 32'(u_if.win_last), 32'd0);
        check("s6/rst_err", 32'(u_if.frame_err), 32'd0);
        check("s6/rst_pixels", u_if.win_pixels, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q4.delete();
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, pixel_t'($urandom));
        play(img, N, 0, ta);
        add_expected(img, ta, N);
        compare("s6");

        // Minimum 2x2 frame on the second instance
        @(posedge clk); #1;
        u_if2.pix_valid = 1'b1; u_if2.pix_sof = 1'b1; u_if2.pix_in = 8'd7;
        @(posedge clk); #1;
        u_if2.pix_sof = 1'b0; u_if2.pix_in = 8'd8;
        @(posedge clk); #1;
        u_if2.pix_in = 8'd9;
        @(posedge clk); #1;
        u_if2.pix_in = 8'd10;
        t_last = cyc + 1;
        @(posedge clk); #1;
        u_if2.pix_valid = 1'b0;
        @(negedge clk);
        check("s7/state", 32'(u_dut2.r_state), 32'(IDLE));
        @(posedge clk); #1;
        u_if2.pix_valid = 1'b1; u_if2.pix_in = 8'd55;
        repeat (3) @(posedge clk);
        #1 u_if2.pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("s7/count", 32'(q2.size()), 32'd1);
        check("s7/px", (q2.size() > 0) ? q2[0].px : 32'd0, {8'd10, 8'd9, 8'd8, 8'd7});
        check("s7/last", (q2.size() > 0) ? 32'(q2[0].last) : 32'd0, 32'd1);
        check("s7/time", (q2.size() > 0) ? 32'(q2[0].t) : 32'd0, 32'(t_last));

        check("stray_last", 32'(stray), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
